// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply-divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign-fixed at the end.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               zdiv_q, zdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        a_neg = op[0] & dataA[WIDTH-1];
        b_neg = op[0] & dataB[WIDTH-1];
        a_mag = a_neg ? -dataA : dataA;
        b_mag = b_neg ? -dataB : dataB;

        // prod_q holds {partial product, remaining multiplier} while multiplying
        // and {partial remainder, dividend/quotient bits} while dividing.
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};

        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};

        prod_fix = neg_q ? -prod_q : prod_q;
        quo_fix  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        zdiv_d   = zdiv_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            is_div_d = op[1];
                            opnd_d   = op[1] ? b_mag : a_mag;
                            prod_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            zdiv_d   = op[1] & (dataB == '0);
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        OP_MTHI: hi_d = dataA;
                        OP_MTLO: lo_d = dataA;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = is_div_q ? div_next : mul_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    // Zero divisor: magnitude remainder already equals |dataA|, so only
                    // the quotient needs forcing to all ones.
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = zdiv_q ? '1 : quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d = 1'b1;
                    dbz_d  = zdiv_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            zdiv_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            zdiv_q   <= zdiv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit with architectural HI/LO registers for the pipelined MIPS-Lite core.
- Replaces the fixed-width unsigned multiplier and the separate HI/LO block.
- Sits beside the ALU in EX.
- Supports signed and unsigned multiply and divide, plus MTHI/MTLO.
- Raises busy so the hazard logic can stall mfhi/mflo and back-to-back mult/div.
- Accepts a cancel from the pipeline flush logic.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are WIDTH each; must be >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
clk          input   1        clock, rising edge
rst          input   1        asynchronous reset, active-high
start        input   1        launch op on this edge (sampled only when busy=0)
op           input   3        000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
dataA        input   WIDTH    rs value (multiplicand / dividend / MTHI-MTLO source)
dataB        input   WIDTH    rt value (multiplier / divisor)
cancel       input   1        abort in-flight op (pipeline flush)
busy         output  1        op in progress; HI/LO not yet valid
done         output  1        one-cycle pulse: HI/LO just updated by mult/div
div_by_zero  output  1        one-cycle pulse coincident with done for DIV/DIVU with dataB=0
hi           output  WIDTH    HI register
lo           output  WIDTH    LO register

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. No partial result survives.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, cancel=0, op in {MULTU, MULT, DIVU, DIV}:
  - Latch operand magnitudes. For signed ops, two's-complement absolute values; record result signs.
  - Latch op; counter=0.
  - Next state RUN; busy=1 from the following cycle.
- IDLE, start=1, op=MTHI or MTLO: hi (or lo) <= dataA at that edge. No busy, no done.
- IDLE, op=11x: ignored.
- RUN, multiply: radix-2 shift-add, one multiplier bit per edge, into a 2*WIDTH product.
- RUN, divide: restoring shift-subtract, one quotient bit per edge.
- RUN: counter increments each edge; after WIDTH edges, go to FIX.
- FIX, one edge:
  - Apply sign correction.
  - Write hi/lo; done=1 for exactly this following cycle.
  - busy=0; state IDLE.
- Latency: the start edge is E0; hi/lo are valid and done is high after edge E(WIDTH+1). busy is high after edges E0..E(WIDTH). For WIDTH=32, that is 33 busy cycles.
- Result mapping:
  - Multiply: {hi,lo} = full 2*WIDTH product; MULT is signed x signed.
  - Divide: lo=quotient, hi=remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow (min / -1): lo=min (0x80000000 for WIDTH=32), hi=0. This falls out of the magnitude algorithm; no special-case is needed.
- Divide by zero: the FSM still runs the full latency. Result lo=all ones, hi=dataA (unmodified, for both DIV and DIVU). div_by_zero pulses with done.
- start while busy=1: ignored; the op in flight is unaffected. The launching stage must stall.
- cancel=1 in RUN or FIX: next edge state=IDLE, busy=0; hi/lo keep their pre-op values; no done.
- cancel and start in the same IDLE cycle: cancel wins, nothing launches, MTHI/MTLO are also suppressed.
- cancel in IDLE without start: no effect.
- done and div_by_zero are low in every cycle other than the one after the FIX edge.
- A new start may be presented in the same cycle done is high, because busy=0. Back-to-back throughput is one op per WIDTH+2 cycles.
- hi/lo change only at a FIX edge, an MTHI/MTLO edge, or reset.

Test Plan:
- WIDTH=32, reset, then check outputs -> hi=0, lo=0, busy=0, done=0. Assert rst mid-RUN -> all outputs return to 0 asynchronously, before the next clk edge.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles; after E33, hi=0xFFFFFFFE, lo=0x00000001, done pulses once. MULT 0xFFFFFFFD(-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> after 33 cycles lo=0xFFFFFFFF, hi=5, done=1 and div_by_zero=1 in the same single cycle.
- Preload with MTHI 0x1234, MTLO 0x5678 (no busy). Launch MULTU 3x4. Pulse start with DIVU at cycle 5 -> ignored. Pulse cancel at cycle 10 -> busy falls next edge, no done, hi=0x1234, lo=0x5678.
- Back-to-back: present MULT on the done cycle of a prior DIVU -> second op accepted; results correct for both; no lost or duplicated done pulse. Repeat with WIDTH=8: 0xFF x 0xFF unsigned -> hi=0xFE, lo=0x01 after 9 busy cycles.
